// File: rtl/serial_pattern_tx.sv
// Serial bit-pattern transmitter: shifts a captured pattern out MSB-first,
// repeating it a programmed number of times with optional zero gaps between.
module serial_pattern_tx #(
  parameter int W  = 8,
  parameter int LW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [W-1:0]  pat_in,
  input  logic [LW-1:0] pat_len,
  input  logic [7:0]    rep,
  input  logic [3:0]    gap,
  output logic          o,
  output logic          o_vld,
  output logic          frame_start,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP,
    S_DONE
  } state_t;

  localparam logic [LW-1:0] W_L   = LW'(W);
  localparam logic [LW-1:0] ONE_L = LW'(1);

  state_t        state;
  logic [W-1:0]  pat_r;
  logic [LW-1:0] len_r;
  logic [7:0]    rep_r;
  logic [3:0]    gap_r;
  logic [LW-1:0] bit_idx;
  logic [3:0]    gap_cnt;

  logic [LW-1:0] len_clamped;
  logic [LW-1:0] first_idx;
  logic [7:0]    rep_next;

  // Select one pattern bit by an LW-wide index without a mismatched-width part select.
  function automatic logic pick_bit(input logic [W-1:0] p, input logic [LW-1:0] idx);
    logic r;
    r = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (idx == LW'(i)) r = p[i];
    end
    return r;
  endfunction

  always_comb begin
    len_clamped = (pat_len > W_L) ? W_L : pat_len;
    first_idx   = len_r - ONE_L;
    rep_next    = rep_r - 8'd1;
  end

  // Single FSM: every output is a register updated alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      pat_r       <= '0;
      len_r       <= '0;
      rep_r       <= '0;
      gap_r       <= '0;
      bit_idx     <= '0;
      gap_cnt     <= '0;
      o           <= 1'b0;
      o_vld       <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else if (abort && state != S_IDLE) begin
      state       <= S_IDLE;
      o           <= 1'b0;
      o_vld       <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && pat_len != '0 && rep != 8'd0) begin
            pat_r       <= pat_in;
            len_r       <= len_clamped;
            rep_r       <= rep;
            gap_r       <= gap;
            bit_idx     <= len_clamped - ONE_L;
            o           <= pick_bit(pat_in, len_clamped - ONE_L);
            o_vld       <= 1'b1;
            frame_start <= 1'b1;
            busy        <= 1'b1;
            state       <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          frame_start <= 1'b0;
          if (bit_idx != '0) begin
            bit_idx <= bit_idx - ONE_L;
            o       <= pick_bit(pat_r, bit_idx - ONE_L);
          end else begin
            // Bit 0 just went out: this repetition is complete.
            rep_r <= rep_next;
            if (rep_next == 8'd0) begin
              state <= S_DONE;
              o     <= 1'b0;
              o_vld <= 1'b0;
              done  <= 1'b1;
            end else if (gap_r == 4'd0) begin
              bit_idx     <= first_idx;
              o           <= pick_bit(pat_r, first_idx);
              frame_start <= 1'b1;
            end else begin
              state   <= S_GAP;
              gap_cnt <= gap_r;
              o       <= 1'b0;
              o_vld   <= 1'b0;
            end
          end
        end

        S_GAP: begin
          if (gap_cnt == 4'd1) begin
            state       <= S_SHIFT;
            bit_idx     <= first_idx;
            o           <= pick_bit(pat_r, first_idx);
            o_vld       <= 1'b1;
            frame_start <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Bench for serial_pattern_tx: a per-cycle expected-output list is built from
// the transfer rules and compared against the DUT every cycle.
module tb_serial_pattern_tx;

  localparam int W  = 8;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [W-1:0]  pat_in;
  logic [LW-1:0] pat_len;
  logic [7:0]    rep;
  logic [3:0]    gap;
  logic          o;
  logic          o_vld;
  logic          frame_start;
  logic          busy;
  logic          done;

  int n_cmp  = 0;
  int n_fail = 0;

  // Expected {o, o_vld, frame_start, busy, done} for each cycle after start.
  logic [4:0] exp_q[$];

  serial_pattern_tx #(.W(W), .LW(LW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .pat_in      (pat_in),
    .pat_len     (pat_len),
    .rep         (rep),
    .gap         (gap),
    .o           (o),
    .o_vld       (o_vld),
    .frame_start (frame_start),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [4:0] expv);
    logic [4:0] obs;
    obs = {o, o_vld, frame_start, busy, done};
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("[TB] FAIL %s observed {o,vld,fs,busy,done}=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic buildModel(input logic [7:0] p, input int len, input int reps, input int g);
    int  l;
    logic b_val;
    l = (len > W) ? W : len;
    exp_q.delete();
    for (int r = 0; r < reps; r++) begin
      for (int b = l - 1; b >= 0; b--) begin
        b_val = (((p >> b) & 8'h01) != 8'h00);
        exp_q.push_back({b_val, 1'b1, (b == l - 1), 1'b1, 1'b0});
      end
      if (r < reps - 1)
        for (int k = 0; k < g; k++) exp_q.push_back(5'b00010);
    end
    exp_q.push_back(5'b00011);
    exp_q.push_back(5'b00000);
  endtask

  // Starts a transfer at a negedge and checks every following cycle.
  // kill_kind: 1 = abort, 2 = rst, asserted in cycle kill_at.
  task automatic applyStimulus(input string tag, input logic [7:0] p, input logic [3:0] len,
                               input logic [7:0] reps, input logic [3:0] g, input int kill_at,
                               input int kill_kind, input logic abort_with_start, input bit noise);
    int n;
    buildModel(p, int'(len), int'(reps), int'(g));
    n       = exp_q.size();
    pat_in  = p;
    pat_len = len;
    rep     = reps;
    gap     = g;
    start   = 1'b1;
    abort   = abort_with_start;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    for (int i = 1; i <= n; i++) begin
      checkOutput(tag, exp_q[i-1]);
      if (i == kill_at) begin
        start = 1'b0;
        if (kill_kind == 1) abort = 1'b1;
        else rst = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        rst   = 1'b0;
        checkOutput({tag, "_kill"}, 5'b00000);
        @(negedge clk);
        checkOutput({tag, "_after_kill"}, 5'b00000);
        return;
      end
      if (noise) begin
        pat_in  = 8'($urandom);
        pat_len = 4'($urandom);
        rep     = 8'($urandom);
        gap     = 4'($urandom);
        start   = (i < n) ? 1'($urandom) : 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic checkIgnored(input string tag, input logic [3:0] len, input logic [7:0] reps);
    pat_in  = 8'hFF;
    pat_len = len;
    rep     = reps;
    gap     = 4'd0;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput(tag, 5'b00000);
    @(negedge clk);
    checkOutput(tag, 5'b00000);
  endtask

  initial begin
    int lc, nb, kat, kk;
    logic [7:0] rp;
    logic [3:0] rl, rg;
    logic [7:0] rr;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    pat_in = '0; pat_len = '0; rep = '0; gap = '0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset", 5'b00000);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle", 5'b00000);

    applyStimulus("single",     8'h09, 4'd4,  8'd1, 4'd0, 0, 0, 1'b0, 1'b0);
    applyStimulus("b2b",        8'h09, 4'd4,  8'd3, 4'd0, 0, 0, 1'b0, 1'b0);
    applyStimulus("gap",        8'h09, 4'd4,  8'd2, 4'd2, 0, 0, 1'b0, 1'b0);
    checkIgnored("rep0", 4'd4, 8'd0);
    checkIgnored("len0", 4'd0, 8'd2);
    applyStimulus("clamp",      8'hA5, 4'd12, 8'd1, 4'd0, 0, 0, 1'b0, 1'b0);
    applyStimulus("interfere",  8'h09, 4'd4,  8'd1, 4'd0, 0, 0, 1'b0, 1'b1);
    applyStimulus("abort",      8'h5A, 4'd8,  8'd1, 4'd0, 3, 1, 1'b0, 1'b0);
    applyStimulus("abort_idle", 8'hC3, 4'd8,  8'd1, 4'd0, 0, 0, 1'b1, 1'b0);
    applyStimulus("rst_gap",    8'h09, 4'd4,  8'd2, 4'd3, 6, 2, 1'b0, 1'b0);
    applyStimulus("fresh",      8'h09, 4'd4,  8'd1, 4'd0, 0, 0, 1'b0, 1'b0);

    for (int t = 0; t < 25; t++) begin
      rp  = 8'($urandom);
      rl  = 4'($urandom_range(1, 11));
      rr  = 8'($urandom_range(1, 5));
      rg  = 4'($urandom_range(0, 4));
      lc  = (int'(rl) > W) ? W : int'(rl);
      nb  = lc * int'(rr) + (int'(rr) - 1) * int'(rg) + 1;
      kk  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      kat = (kk != 0) ? int'($urandom_range(1, nb)) : 0;
      applyStimulus("random", rp, rl, rr, rg, kat, kk, 1'b0, 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_pattern_tx.md
Name: serial_pattern_tx

Overview:
- Serial bit-pattern transmitter for the bit-serial input of our sequence-detector FSMs.
- Captures a parallel pattern of up to W bits and shifts it out MSB-first, one bit per clock.
- Repeats the pattern a programmed number of times, optionally separated by zero-filled gap cycles.
- Reports progress through busy, frame_start and done so a bench or upstream controller can sequence transfers.

Parameters:
W, 8, maximum pattern length in bits
LW, 4, width of pat_len; must satisfy 2**LW > W

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request to transmit; sampled only in IDLE
abort  input  1  synchronous cancel of an active transfer
pat_in  input  W  pattern; bit pat_len-1 is transmitted first
pat_len  input  LW  number of valid pattern bits, 1..W
rep  input  8  number of pattern transmissions, 1..255
gap  input  4  zero cycles inserted between repetitions, 0..15
o  output  1  serial data bit
o_vld  output  1  o carries a pattern bit this cycle
frame_start  output  1  high with the first bit of every repetition
busy  output  1  transfer in progress
done  output  1  one-cycle pulse after the last bit of the last repetition

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE; o=0, o_vld=0, frame_start=0, busy=0, done=0; all internal registers cleared.
- Reset has priority over abort and start.
- Reset during a transfer terminates it immediately, with no done pulse.
- All outputs are registered.
- States: IDLE, SHIFT, GAP, DONE.
- IDLE:
  - start=1 with pat_len!=0 and rep!=0: capture pat_in, pat_len, rep and gap; go to SHIFT.
  - pat_len > W is clamped to W.
  - start with pat_len=0 or rep=0 is ignored: stay IDLE, busy stays 0.
- SHIFT:
  - First SHIFT cycle is the cycle after start is accepted: o=pat[len-1], o_vld=1, busy=1, frame_start=1.
  - Each following cycle outputs the next lower bit, with frame_start=0.
  - Exactly len cycles per repetition; pattern bits at or above len are never output.
- End of a repetition (after bit 0 is output):
  - Decrement the remaining-repetition count.
  - If repetitions remain and gap=0: next cycle is the first bit of the next repetition. Output is contiguous and frame_start=1 again.
  - If repetitions remain and gap>0: go to GAP.
  - If no repetitions remain: go to DONE.
- GAP:
  - Lasts exactly gap cycles with o=0, o_vld=0, busy=1.
  - Then return to SHIFT at bit len-1 with frame_start=1.
- DONE:
  - One cycle: done=1, busy=1, o=0, o_vld=0; then IDLE.
  - start is accepted again from the IDLE cycle that follows DONE.
- Whenever o_vld=0, o is driven 0.
- start asserted while busy=1 is ignored.
- pat_in, pat_len, rep and gap may change freely during a transfer without effect.
- abort=1 in SHIFT, GAP or DONE:
  - Next cycle: IDLE, all outputs 0, no done pulse.
  - Any partially transmitted repetition is dropped.
  - abort in IDLE has no effect.
  - abort and start together in IDLE: abort has no effect; start is evaluated normally.
- Total transfer timing: busy is high for rep*len + (rep-1)*gap + 1 cycles.
- Counters:
  - Bit index is LW bits and counts down to 0; it never wraps.
  - Repetition counter is 8 bits; gap counter is 4 bits.

Test Plan:
- Basic single repetition:
  - Stimulus: pat_in=8'h09, pat_len=4, rep=1, gap=0, start pulse at cycle 0.
  - Required: cycles 1-4 give o=1,0,0,1 with o_vld=1; frame_start=1 only in cycle 1; done=1 in cycle 5; busy high cycles 1-5.
  - Chained into the 1001 detector, its y=1 exactly once.
- Back-to-back repetitions: pat_in=8'h09, pat_len=4, rep=3, gap=0 -> 12 contiguous valid bits 100110011001; frame_start in cycles 1, 5 and 9; done in cycle 13; detector y pulses 3 times.
- Gap insertion: pat_len=4, pat_in=8'h09, rep=2, gap=2 -> o/o_vld pattern 1001, 00 (o_vld=0), 1001; done in cycle 11.
- Illegal and clamped requests:
  - start with rep=0 -> busy stays 0 and no output.
  - start with pat_len=0 -> busy stays 0 and no output.
  - pat_len=12 with W=8, pat_in=8'hA5 -> 8 bits 10100101 are sent.
- Interference during a transfer:
  - start pulse in cycle 2 of a rep=1 transfer -> ignored.
  - A new pat_in applied mid-transfer does not alter the output.
- Abort and reset:
  - abort in cycle 3 of a pat_len=8 transfer -> cycle 4 has busy=0, o_vld=0 and no done.
  - rst mid-GAP -> all outputs 0 next cycle; a fresh start afterwards transmits correctly.
